// File: rtl/pong_match_ctrl.sv
// Match sequencer for Pong: counts points from the ball block, detects the winner
// and holds the ball at centre for a timed serve delay between points.
module pong_match_ctrl #(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 50_000_000,
    parameter int unsigned DELAY_W     = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       player_scored,
    input  logic       cpu_scored,
    output logic [3:0] player_score,
    output logic [3:0] cpu_score,
    output logic       player_win,
    output logic       cpu_win,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    localparam logic [3:0]         WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [DELAY_W-1:0] DELAY_END = DELAY_W'(SERVE_DELAY - 1);

    state_t             cur, nxt;
    logic               p_q, c_q, start_q;
    logic [DELAY_W-1:0] cnt, cnt_nxt;
    logic [3:0]         p_score_nxt, c_score_nxt;
    logic               p_win_nxt, c_win_nxt, dir_nxt, hold_nxt;
    logic               p_edge, c_edge, start_edge;

    assign p_edge     = player_scored & ~p_q;
    assign c_edge     = cpu_scored & ~c_q;
    assign start_edge = start & ~start_q;
    assign state      = cur;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur          <= IDLE;
            p_q          <= 1'b0;
            c_q          <= 1'b0;
            start_q      <= 1'b0;
            cnt          <= '0;
            player_score <= 4'd0;
            cpu_score    <= 4'd0;
            player_win   <= 1'b0;
            cpu_win      <= 1'b0;
            ball_hold    <= 1'b1;
            serve_dir    <= 1'b0;
        end else begin
            cur          <= nxt;
            p_q          <= player_scored;
            c_q          <= cpu_scored;
            start_q      <= start;
            cnt          <= cnt_nxt;
            player_score <= p_score_nxt;
            cpu_score    <= c_score_nxt;
            player_win   <= p_win_nxt;
            cpu_win      <= c_win_nxt;
            ball_hold    <= hold_nxt;
            serve_dir    <= dir_nxt;
        end
    end

    // Next-state logic; player edge has priority over a simultaneous cpu edge
    always_comb begin
        nxt = IDLE;
        case (cur)
            IDLE:       nxt = start ? SERVE_WAIT : IDLE;
            SERVE_WAIT: nxt = (cnt == DELAY_END) ? PLAY : SERVE_WAIT;
            PLAY:       nxt = (p_edge | c_edge) ? POINT : PLAY;
            POINT:      nxt = (player_score == WIN_VAL || cpu_score == WIN_VAL)
                              ? GAME_OVER : SERVE_WAIT;
            GAME_OVER:  nxt = start_edge ? IDLE : GAME_OVER;
            default:    nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the serve counter
    always_comb begin
        cnt_nxt     = cnt;
        p_score_nxt = player_score;
        c_score_nxt = cpu_score;
        p_win_nxt   = player_win;
        c_win_nxt   = cpu_win;
        dir_nxt     = serve_dir;
        hold_nxt    = (nxt != PLAY);
        case (cur)
            IDLE: begin
                if (start) begin
                    cnt_nxt     = '0;
                    p_score_nxt = 4'd0;
                    c_score_nxt = 4'd0;
                    p_win_nxt   = 1'b0;
                    c_win_nxt   = 1'b0;
                end
            end
            SERVE_WAIT: cnt_nxt = (cnt == DELAY_END) ? '0 : cnt + DELAY_W'(1);
            PLAY: begin
                if (p_edge) begin
                    p_score_nxt = player_score + 4'd1;
                    dir_nxt     = 1'b1;
                end else if (c_edge) begin
                    c_score_nxt = cpu_score + 4'd1;
                    dir_nxt     = 1'b0;
                end
            end
            POINT: begin
                if (player_score == WIN_VAL)   p_win_nxt = 1'b1;
                else if (cpu_score == WIN_VAL) c_win_nxt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with WIN_SCORE=3 and SERVE_DELAY=4.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, player_scored, cpu_scored;
    logic [3:0] player_score, cpu_score;
    logic       player_win, cpu_win, ball_hold, serve_dir;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] S_IDLE = 0, S_SW = 1, S_PLAY = 2, S_POINT = 3, S_GO = 4;

    pong_match_ctrl #(.WIN_SCORE(3), .SERVE_DELAY(4), .DELAY_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .player_scored(player_scored), .cpu_scored(cpu_scored),
        .player_score(player_score), .cpu_score(cpu_score),
        .player_win(player_win), .cpu_win(cpu_win),
        .ball_hold(ball_hold), .serve_dir(serve_dir), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_play();
        for (int i = 0; i < 20; i++) begin
            if (state == 3'(S_PLAY)) break;
            step();
        end
        chk("wait_play", 32'(state), S_PLAY);
    endtask

    // One-cycle score pulse issued from PLAY; returns in the POINT cycle
    task automatic score(input bit is_player);
        if (is_player) player_scored = 1'b1;
        else           cpu_scored    = 1'b1;
        step();
        player_scored = 1'b0;
        cpu_scored    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; player_scored = 1'b0; cpu_scored = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), S_IDLE);
        chk("rst_pscore", 32'(player_score), 0);
        chk("rst_cscore", 32'(cpu_score), 0);
        chk("rst_hold", 32'(ball_hold), 1);
        chk("rst_dir", 32'(serve_dir), 0);
        chk("rst_wins", 32'({player_win, cpu_win}), 0);
        rst = 1'b0;
        step();
        chk("idle_after_rst", 32'(state), S_IDLE);

        // Start: exactly 4 SERVE_WAIT cycles, then PLAY
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sw_state", 32'(state), S_SW);
            chk("sw_hold", 32'(ball_hold), 1);
            step();
        end
        chk("play_state", 32'(state), S_PLAY);
        chk("play_hold", 32'(ball_hold), 0);

        // Long player level scores once
        player_scored = 1'b1;
        step();
        chk("lvl_point_state", 32'(state), S_POINT);
        chk("lvl_pscore", 32'(player_score), 1);
        chk("lvl_dir", 32'(serve_dir), 1);
        chk("lvl_point_hold", 32'(ball_hold), 1);
        step();
        chk("lvl_sw_state", 32'(state), S_SW);
        repeat (18) step();
        chk("lvl_pscore_hold", 32'(player_score), 1);
        chk("lvl_back_play", 32'(state), S_PLAY);
        player_scored = 1'b0;
        step();

        // Simultaneous edges: player wins the tie
        player_scored = 1'b1; cpu_scored = 1'b1;
        step();
        player_scored = 1'b0; cpu_scored = 1'b0;
        chk("tie_state", 32'(state), S_POINT);
        chk("tie_pscore", 32'(player_score), 2);
        chk("tie_cscore", 32'(cpu_score), 0);
        chk("tie_dir", 32'(serve_dir), 1);
        step();
        chk("tie_sw", 32'(state), S_SW);

        // Cpu runs to 3; start raised during play so it is already high at GAME_OVER
        wait_play();
        score(1'b0);
        chk("c1_score", 32'(cpu_score), 1);
        chk("c1_dir", 32'(serve_dir), 0);
        step();
        wait_play();
        score(1'b0);
        chk("c2_score", 32'(cpu_score), 2);
        step();
        wait_play();
        start = 1'b1;
        score(1'b0);
        chk("c3_point", 32'(state), S_POINT);
        chk("c3_score", 32'(cpu_score), 3);
        step();
        chk("go_state", 32'(state), S_GO);
        chk("go_cwin", 32'(cpu_win), 1);
        chk("go_pwin", 32'(player_win), 0);
        chk("go_hold", 32'(ball_hold), 1);
        score(1'b0);
        step();
        chk("go_cscore_frozen", 32'(cpu_score), 3);
        chk("go_start_level_ignored", 32'(state), S_GO);

        // Restart needs a fresh start edge; two cycles to SERVE_WAIT
        start = 1'b0;
        step();
        chk("go_start_low", 32'(state), S_GO);
        start = 1'b1;
        step();
        chk("restart_idle", 32'(state), S_IDLE);
        step();
        start = 1'b0;
        chk("restart_sw", 32'(state), S_SW);
        chk("restart_scores", 32'({player_score, cpu_score}), 0);
        chk("restart_wins", 32'({player_win, cpu_win}), 0);

        // Build 2:1 with serve_dir=1, then async reset mid SERVE_WAIT
        wait_play();
        score(1'b0);
        step();
        wait_play();
        score(1'b1);
        step();
        wait_play();
        score(1'b1);
        step();
        chk("pre_rst_state", 32'(state), S_SW);
        chk("pre_rst_scores", 32'({player_score, cpu_score}), 32'h21);
        chk("pre_rst_dir", 32'(serve_dir), 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), S_IDLE);
        chk("async_rst_scores", 32'({player_score, cpu_score}), 0);
        chk("async_rst_hold", 32'(ball_hold), 1);
        chk("async_rst_dir", 32'(serve_dir), 0);
        chk("async_rst_wins", 32'({player_win, cpu_win}), 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", 32'(state), S_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match sequencer for the Pong ball datapath. It counts points from the ball block's player_Scored and cpu_Scored indications and detects the winner. It drives the player_Win and cpu_Win inputs back to the ball block. It also freezes the ball during a timed serve delay between points. It sits between the ball block, the score display and the start button.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..15.
SERVE_DELAY, 50_000_000, clk cycles the ball is held before each serve; must be >= 1.
DELAY_W, 26, width of the serve delay counter; must satisfy 2^DELAY_W > SERVE_DELAY.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  debounced, clk-synchronous start/restart request, level
player_scored  in  1  level from ball block; high while the ball is past the right bound
cpu_scored  in  1  level from ball block; high while the ball is past the left bound
player_score  out  4  player points, unsigned
cpu_score  out  4  cpu points, unsigned
player_win  out  1  player has reached WIN_SCORE; feeds the ball block's player_Win
cpu_win  out  1  cpu has reached WIN_SCORE; feeds the ball block's cpu_Win
ball_hold  out  1  high = ball must stay at centre; ORed into the ball block's serve/win reset path
serve_dir  out  1  0 = next serve goes toward cpu (right), 1 = toward player (left)
state  out  3  current FSM state encoding, for debug and display

Behaviour:
- Reset is asynchronous and active-high. While rst is high and after it releases:
  - FSM is in IDLE.
  - player_score = 0 and cpu_score = 0.
  - player_win = 0 and cpu_win = 0.
  - ball_hold = 1 and serve_dir = 0.
  - Delay counter = 0 and edge-detect registers = 0.
- Edge detection: player_scored and cpu_scored are each registered once (p_q, c_q).
  - A rising edge is input & ~q.
  - Edges are acted on only in PLAY.
  - A level held across many cycles counts as exactly one point.
- State encodings: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4. Any other encoding goes to IDLE on the next clk.
- IDLE:
  - ball_hold = 1.
  - When start = 1: clear both scores and both wins, clear the delay counter, go to SERVE_WAIT.
- SERVE_WAIT:
  - ball_hold = 1.
  - The counter increments each cycle.
  - When counter == SERVE_DELAY-1: clear the counter and go to PLAY. Total wait is SERVE_DELAY cycles.
- PLAY:
  - ball_hold = 0.
  - Player rising edge: player_score += 1, serve_dir <= 1, go to POINT.
  - Cpu rising edge: cpu_score += 1, serve_dir <= 0, go to POINT.
  - Both edges in the same cycle: the player is awarded the point and the cpu edge is discarded.
  - The score update is registered, so it is visible on the cycle after the edge cycle.
- POINT (one cycle):
  - ball_hold = 1.
  - If player_score == WIN_SCORE: player_win <= 1, go to GAME_OVER.
  - Else if cpu_score == WIN_SCORE: cpu_win <= 1, go to GAME_OVER.
  - Otherwise go to SERVE_WAIT.
- GAME_OVER:
  - ball_hold = 1; scores and wins hold.
  - A start rising edge (start & ~start_q) goes to IDLE.
  - Because start is still high when IDLE is entered, IDLE immediately clears the match and goes to SERVE_WAIT. Restart therefore takes 2 cycles.
  - A start level already high on entry to GAME_OVER is ignored until it has gone low and risen again.
- Score arithmetic: 4-bit unsigned. WIN_SCORE <= 15 guarantees no wrap, and a score never exceeds WIN_SCORE.
- Scoring levels that arrive outside PLAY are ignored. The edge registers still track the inputs, so a level still high when PLAY is entered does not score.
- rst asserted mid-match, in any state: immediate return to reset values. No point is awarded for an edge in flight.

Test Plan:
- WIN_SCORE=3, SERVE_DELAY=4: release rst, start=1 for 1 cycle -> SERVE_WAIT for exactly 4 cycles with ball_hold=1, then PLAY with ball_hold=0.
- In PLAY, hold player_scored high for 20 cycles -> player_score 0->1 exactly once, serve_dir=1, one POINT cycle, then SERVE_WAIT.
- Drive player_scored and cpu_scored rising in the same PLAY cycle -> player_score+1, cpu_score unchanged, serve_dir=1.
- Three cpu_scored pulses separated by PLAY periods -> cpu_score=3, cpu_win=1 on the POINT cycle after the third edge, GAME_OVER with ball_hold=1; a further cpu_scored pulse leaves cpu_score=3.
- In GAME_OVER, hold start high from entry -> stays in GAME_OVER; drop start, then raise it -> 2 cycles later state=SERVE_WAIT with scores=0 and wins=0.
- Assert rst mid-SERVE_WAIT with scores 2:1 -> all outputs return to reset values in the same cycle (asynchronous reset), state=IDLE.
